// File: rtl/logicnet_neuron_scheduler.sv
// logicnet_neuron_scheduler: time-multiplexes one truth-table RAM across a layer of LogicNet neurons
module logicnet_neuron_scheduler #(
  parameter int NEURONS  = 8,
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2,
  parameter int IDX_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NEURONS*IN_BITS-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NEURONS*OUT_BITS-1:0]  m_data,
  input  logic                         cfg_we,
  input  logic [IDX_W+IN_BITS-1:0]     cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  output logic                         cfg_ready,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] idx, rd_idx;
  logic [NEURONS*IN_BITS-1:0] fanins;
  logic [OUT_BITS-1:0] mem [2**(IDX_W+IN_BITS)];
  logic [OUT_BITS-1:0] rd_data;
  logic [IN_BITS-1:0] fanin;
  logic rd_pend, last, cfg_ok;

  assign s_ready   = state == IDLE;
  assign cfg_ready = state == IDLE;
  assign m_valid   = state == OUT;
  assign busy      = state != IDLE;

  // Current neuron's fan-in, last-neuron flag, and in-range check for config writes
  always_comb begin
    fanin    = fanins[idx*IN_BITS +: IN_BITS];
    last     = idx == IDX_W'(NEURONS - 1);
    cfg_ok   = 32'(cfg_addr[IDX_W+IN_BITS-1 -: IDX_W]) < NEURONS;
    state_nx = state == IDLE  ? (s_valid ? RUN : IDLE) :
               state == RUN   ? (last ? FLUSH : RUN) :
               state == FLUSH ? OUT :
                                (m_ready ? IDLE : OUT);
  end

  // State register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // Sample latch, neuron index walk, and one-cycle-delayed result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      rd_pend <= 1'b0;
      m_data  <= '0;
    end else begin
      rd_pend <= state == RUN;
      if (state == IDLE && s_valid) begin
        fanins <= s_data;
        idx    <= '0;
      end
      if (state == RUN) begin
        rd_idx <= idx;
        if (!last) idx <= idx + IDX_W'(1);
      end
      if (rd_pend) m_data[rd_idx*OUT_BITS +: OUT_BITS] <= rd_data;
    end
  end

  // Shared table RAM: writes only while idle so they never race a lookup; contents survive reset
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE && cfg_ok) mem[cfg_addr] <= cfg_data;
    if (state == RUN) rd_data <= mem[{idx, fanin}];
  end
endmodule

// File: tb/tb_logicnet_neuron_scheduler.sv
// tb_logicnet_neuron_scheduler: randomized self-checking bench against a table-lookup model
module tb_logicnet_neuron_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
  logic [47:0] s_data = '0;
  logic [15:0] m_data;
  logic cfg_we = 1'b0, cfg_ready, busy;
  logic [8:0] cfg_addr = '0;
  logic [1:0] cfg_data = '0;
  logic [1:0] tbl [8][64];
  int n_chk = 0, n_fail = 0;
  logic [15:0] q [$];

  logicnet_neuron_scheduler dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [47:0] d);
    logic [15:0] r;
    for (int k = 0; k < 8; k++) r[k*2 +: 2] = tbl[k][d[k*6 +: 6]];
    return r;
  endfunction

  function automatic logic [47:0] ramp_data;
    logic [47:0] d;
    for (int k = 0; k < 8; k++) d[k*6 +: 6] = 6'(k);
    return d;
  endfunction

  task automatic cfg_write(input logic [8:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick;
    cfg_we = 1'b0;
    tbl[a[8:6]][a[5:0]] = d;
  endtask

  task automatic run_sample(input string tag, input logic [47:0] d, input bit wr,
                            input logic [8:0] wa, input logic [1:0] wd, input int hold);
    logic [15:0] exp;
    int n;
    n = 0;
    while (!s_ready && n < 50) begin tick; n++; end
    chk({tag, "_ready"}, s_ready, 1'b1);
    if (wr) begin
      cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
      tbl[wa[8:6]][wa[5:0]] = wd;
    end
    exp = model(d);
    s_valid = 1'b1; s_data = d;
    tick;
    s_valid = 1'b0; cfg_we = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin tick; n++; end
    chk({tag, "_lat"}, 64'(n), 64'd9);
    chk({tag, "_data"}, m_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, "_hold_data"}, m_data, exp);
      chk({tag, "_hold_flags"}, {m_valid, s_ready, cfg_ready, busy}, 4'b1001);
    end
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    chk({tag, "_done"}, {m_valid, s_ready}, 2'b01);
  endtask

  initial begin
    logic [47:0] d;
    int n, cyc, last_cyc, got;
    repeat (3) tick;
    chk("rst_flags", {s_ready, m_valid, busy, cfg_ready}, 4'b1001);
    chk("rst_mdata", m_data, 16'h0);
    rst = 1'b0;
    tick;

    for (int a = 0; a < 512; a++) cfg_write(9'(a), 2'(a));
    run_sample("t1", ramp_data(), 1'b0, '0, '0, 0);

    for (int a = 0; a < 64; a++) cfg_write({3'd3, 6'(a)}, (a == 6'b001010) ? 2'b11 : 2'b00);
    d = ramp_data();
    d[18 +: 6] = 6'b001010;
    run_sample("t2", d, 1'b0, '0, '0, 0);
    chk("t2_n3", m_data[7:6], 2'b11);

    run_sample("t3", ramp_data(), 1'b0, '0, '0, 20);

    s_valid = 1'b1; s_data = '0;
    tick;
    s_valid = 1'b0;
    tick; tick;
    chk("t4_cfg_ready", cfg_ready, 1'b0);
    cfg_we = 1'b1; cfg_addr = 9'd0; cfg_data = 2'b11;
    tick;
    cfg_we = 1'b0;
    n = 0;
    while (!m_valid && n < 50) begin tick; n++; end
    chk("t4_first", m_data, model('0));
    m_ready = 1'b1; tick; m_ready = 1'b0;
    run_sample("t4", '0, 1'b0, '0, '0, 0);
    chk("t4_n0", m_data[1:0], tbl[0][0]);

    s_valid = 1'b1; s_data = 48'($urandom) ^ {$urandom, 16'h0};
    tick;
    s_valid = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t5_abort", {m_valid, busy, m_data}, 18'h0);
    run_sample("t5", {$urandom, 16'($urandom)}, 1'b0, '0, '0, 0);

    for (int i = 0; i < 8; i++)
      run_sample("rnd", {$urandom, 16'($urandom)}, 1'b1, 9'($urandom), 2'($urandom), $urandom_range(0, 3));

    s_valid = 1'b1; m_ready = 1'b1; s_data = {$urandom, 16'($urandom)};
    cyc = 0; last_cyc = -1; got = 0;
    while (got < 6 && cyc < 300) begin
      if (s_ready) q.push_back(model(s_data));
      tick;
      cyc++;
      s_data = {$urandom, 16'($urandom)};
      if (m_valid) begin
        chk("t6_data", m_data, (q.size() > 0) ? q.pop_front() : 16'hxxxx);
        if (last_cyc >= 0) chk("t6_period", 64'(cyc - last_cyc), 64'd11);
        last_cyc = cyc;
        got++;
      end
    end
    s_valid = 1'b0;
    chk("t6_count", 64'(got), 64'd6);
    n = 0;
    while (busy && n < 50) begin tick; n++; end
    m_ready = 1'b0;
    chk("t6_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
